// File: rtl/adder_share_pkg.sv
// Shared constants and tag record for the adder time-sharing controller.
package adder_share_pkg;

    localparam int unsigned DEF_W    = 4;
    localparam int unsigned DEF_NREQ = 4;
    localparam int unsigned DEF_LAT  = 1;

    // Tag id is sized for the largest legal NREQ (16); narrower ids are zero-extended.
    localparam int unsigned TAG_IDW  = 4;

    typedef struct packed {
        logic               valid;
        logic [TAG_IDW-1:0] id;
    } tag_t;

endpackage

// File: rtl/adder_share_ctrl_rr_arbiter.sv
// Round-robin arbiter: one-hot grant searched from the pointer, pointer moves past each winner.
module rr_arbiter #(
    parameter int unsigned NREQ = 4,
    localparam int unsigned IDW = $clog2(NREQ)
) (
    input  logic            clk,
    input  logic            rst,
    input  logic [NREQ-1:0] i_req_valid,
    input  logic            i_advance,
    output logic [NREQ-1:0] o_grant,
    output logic [IDW-1:0]  o_grant_id,
    output logic            o_grant_active,
    output logic [IDW-1:0]  o_ptr
);

    logic [IDW-1:0]  r_ptr;
    logic [IDW-1:0]  w_idx;
    logic [IDW-1:0]  w_ptr_next;
    logic            w_found;
    logic [NREQ-1:0] w_grant;
    logic [IDW-1:0]  w_grant_id;

    always_comb begin
        w_grant    = '0;
        w_grant_id = '0;
        w_found    = 1'b0;
        w_idx      = '0;
        for (int unsigned k = 0; k < NREQ; k++) begin
            w_idx = IDW'((32'(r_ptr) + k) % NREQ);
            if (!w_found && i_req_valid[w_idx]) begin
                w_found        = 1'b1;
                w_grant[w_idx] = 1'b1;
                w_grant_id     = w_idx;
            end
        end
    end

    // Explicit wrap so non-power-of-two NREQ never yields an out-of-range pointer.
    assign w_ptr_next = (w_grant_id == IDW'(NREQ - 1)) ? '0 : w_grant_id + 1'b1;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_ptr <= '0;
        end else if (i_advance && w_found) begin
            r_ptr <= w_ptr_next;
        end
    end

    assign o_grant        = w_grant;
    assign o_grant_id     = w_grant_id;
    assign o_grant_active = w_found;
    assign o_ptr          = r_ptr;

endmodule

// File: rtl/adder_share_ctrl.sv
// Time-shares one registered adder among NREQ requesters and returns id-tagged sums in order.
module adder_share_ctrl
    import adder_share_pkg::*;
#(
    parameter int unsigned W    = DEF_W,
    parameter int unsigned NREQ = DEF_NREQ,
    parameter int unsigned LAT  = DEF_LAT,
    localparam int unsigned IDW = $clog2(NREQ)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [NREQ-1:0]   req_valid,
    output logic [NREQ-1:0]   req_ready,
    input  logic [NREQ*W-1:0] req_a,
    input  logic [NREQ*W-1:0] req_b,
    output logic [W-1:0]      add_a,
    output logic [W-1:0]      add_b,
    input  logic [W:0]        add_sum,
    output logic              rsp_valid,
    output logic [IDW-1:0]    rsp_id,
    output logic [W:0]        rsp_sum
);

    logic [NREQ-1:0] w_req_valid;
    logic [NREQ-1:0] w_grant;
    logic [IDW-1:0]  w_grant_id;
    logic            w_grant_active;
    logic [IDW-1:0]  w_ptr;

    tag_t            r_tag [LAT];
    logic            r_rsp_valid;
    logic [IDW-1:0]  r_rsp_id;
    logic [W:0]      r_rsp_sum;

    // Masking requests during reset keeps req_ready low and the pointer untouched.
    assign w_req_valid = rst ? '0 : req_valid;

    rr_arbiter #(
        .NREQ (NREQ)
    ) u_arb (
        .clk            (clk),
        .rst            (rst),
        .i_req_valid    (w_req_valid),
        .i_advance      (w_grant_active),
        .o_grant        (w_grant),
        .o_grant_id     (w_grant_id),
        .o_grant_active (w_grant_active),
        .o_ptr          (w_ptr)
    );

    assign req_ready = w_grant;

    always_comb begin
        add_a = '0;
        add_b = '0;
        for (int unsigned k = 0; k < NREQ; k++) begin
            if (w_grant[k]) begin
                add_a = req_a[k*W +: W];
                add_b = req_b[k*W +: W];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int unsigned s = 0; s < LAT; s++) begin
                r_tag[s] <= '0;
            end
        end else begin
            r_tag[0] <= '{valid: w_grant_active, id: TAG_IDW'(w_grant_id)};
            for (int unsigned s = 1; s < LAT; s++) begin
                r_tag[s] <= r_tag[s-1];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_rsp_valid <= 1'b0;
            r_rsp_id    <= '0;
            r_rsp_sum   <= '0;
        end else begin
            r_rsp_valid <= r_tag[LAT-1].valid;
            r_rsp_id    <= IDW'(r_tag[LAT-1].id);
            r_rsp_sum   <= add_sum;
        end
    end

    assign rsp_valid = r_rsp_valid;
    assign rsp_id    = r_rsp_id;
    assign rsp_sum   = r_rsp_sum;

endmodule

// File: tb/tb_adder_share_ctrl.sv
// Directed bench for adder_share_ctrl with a registered 1-cycle adder model.
module tb_adder_share_ctrl;

    localparam int unsigned W    = 4;
    localparam int unsigned NREQ = 4;
    localparam int unsigned LAT  = 1;

    logic        clk;
    logic        rst;
    logic [3:0]  req_valid;
    logic [3:0]  req_ready;
    logic [15:0] req_a;
    logic [15:0] req_b;
    logic [3:0]  add_a;
    logic [3:0]  add_b;
    logic [4:0]  add_sum;
    logic        rsp_valid;
    logic [1:0]  rsp_id;
    logic [4:0]  rsp_sum;

    int errs   = 0;
    int checks = 0;

    adder_share_ctrl #(
        .W    (W),
        .NREQ (NREQ),
        .LAT  (LAT)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .req_valid (req_valid),
        .req_ready (req_ready),
        .req_a     (req_a),
        .req_b     (req_b),
        .add_a     (add_a),
        .add_b     (add_b),
        .add_sum   (add_sum),
        .rsp_valid (rsp_valid),
        .rsp_id    (rsp_id),
        .rsp_sum   (rsp_sum)
    );

    // Registered simple adder, latency 1.
    always_ff @(posedge clk) begin
        add_sum <= {1'b0, add_a} + {1'b0, add_b};
    end

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct packed {
        logic        rst;
        logic [3:0]  valid;
        logic [15:0] a;
        logic [15:0] b;
        logic [3:0]  ready;
        logic [3:0]  xa;
        logic [3:0]  xb;
        logic        rv;
        logic [1:0]  rid;
        logic [4:0]  rsum;
    } vec_t;

    localparam int NV = 27;
    vec_t tbl [NV];

    function automatic vec_t mk(input logic r, input logic [3:0] v, input logic [15:0] a,
                                input logic [15:0] b, input logic [3:0] rdy, input logic [3:0] xa,
                                input logic [3:0] xb, input logic rv, input logic [1:0] rid,
                                input logic [4:0] rsum);
        vec_t t;
        t.rst = r; t.valid = v; t.a = a; t.b = b; t.ready = rdy;
        t.xa = xa; t.xb = xb; t.rv = rv; t.rid = rid; t.rsum = rsum;
        return t;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errs++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic drive(input logic r, input logic [3:0] v, input logic [15:0] a, input logic [15:0] b);
        rst = r; req_valid = v; req_a = a; req_b = b;
    endtask

    initial begin
        logic got;

        // reset, contention, single request, wrap/skip, max values, reset mid-flight
        tbl[0]  = mk(1, 4'hF, 16'h3210, 16'hAAAA, 4'h0, 4'h0, 4'h0, 0, 2'd0, 5'd0);
        tbl[1]  = mk(1, 4'hF, 16'h3210, 16'hAAAA, 4'h0, 4'h0, 4'h0, 0, 2'd0, 5'd0);
        tbl[2]  = mk(0, 4'hF, 16'h3210, 16'hAAAA, 4'h1, 4'h0, 4'hA, 0, 2'd0, 5'd0);
        tbl[3]  = mk(0, 4'hF, 16'h3210, 16'hAAAA, 4'h2, 4'h1, 4'hA, 0, 2'd0, 5'd0);
        tbl[4]  = mk(0, 4'hF, 16'h3210, 16'hAAAA, 4'h4, 4'h2, 4'hA, 1, 2'd0, 5'd10);
        tbl[5]  = mk(0, 4'hF, 16'h3210, 16'hAAAA, 4'h8, 4'h3, 4'hA, 1, 2'd1, 5'd11);
        tbl[6]  = mk(0, 4'hF, 16'h3210, 16'hAAAA, 4'h1, 4'h0, 4'hA, 1, 2'd2, 5'd12);
        tbl[7]  = mk(0, 4'hF, 16'h3210, 16'hAAAA, 4'h2, 4'h1, 4'hA, 1, 2'd3, 5'd13);
        tbl[8]  = mk(0, 4'hF, 16'h3210, 16'hAAAA, 4'h4, 4'h2, 4'hA, 1, 2'd0, 5'd10);
        tbl[9]  = mk(0, 4'hF, 16'h3210, 16'hAAAA, 4'h8, 4'h3, 4'hA, 1, 2'd1, 5'd11);
        tbl[10] = mk(0, 4'h4, 16'h0900, 16'h0700, 4'h4, 4'h9, 4'h7, 1, 2'd2, 5'd12);
        tbl[11] = mk(0, 4'h0, 16'h0000, 16'h0000, 4'h0, 4'h0, 4'h0, 1, 2'd3, 5'd13);
        tbl[12] = mk(0, 4'h0, 16'h0000, 16'h0000, 4'h0, 4'h0, 4'h0, 1, 2'd2, 5'd16);
        tbl[13] = mk(0, 4'hA, 16'h5040, 16'h1010, 4'h8, 4'h5, 4'h1, 0, 2'd0, 5'd0);
        tbl[14] = mk(0, 4'hA, 16'h5040, 16'h1010, 4'h2, 4'h4, 4'h1, 0, 2'd0, 5'd0);
        tbl[15] = mk(0, 4'hA, 16'h5040, 16'h1010, 4'h8, 4'h5, 4'h1, 1, 2'd3, 5'd6);
        tbl[16] = mk(0, 4'h1, 16'h000F, 16'h000F, 4'h1, 4'hF, 4'hF, 1, 2'd1, 5'd5);
        tbl[17] = mk(0, 4'h1, 16'h000F, 16'h000E, 4'h1, 4'hF, 4'hE, 1, 2'd3, 5'd6);
        tbl[18] = mk(0, 4'h0, 16'h0000, 16'h0000, 4'h0, 4'h0, 4'h0, 1, 2'd0, 5'd30);
        tbl[19] = mk(0, 4'h0, 16'h0000, 16'h0000, 4'h0, 4'h0, 4'h0, 1, 2'd0, 5'd29);
        tbl[20] = mk(0, 4'h0, 16'h0000, 16'h0000, 4'h0, 4'h0, 4'h0, 0, 2'd0, 5'd0);
        tbl[21] = mk(0, 4'h4, 16'h0300, 16'h0300, 4'h4, 4'h3, 4'h3, 0, 2'd0, 5'd0);
        tbl[22] = mk(1, 4'h2, 16'h0020, 16'h0020, 4'h0, 4'h0, 4'h0, 0, 2'd0, 5'd0);
        tbl[23] = mk(0, 4'hA, 16'h0020, 16'h0020, 4'h2, 4'h2, 4'h2, 0, 2'd0, 5'd0);
        tbl[24] = mk(0, 4'h0, 16'h0000, 16'h0000, 4'h0, 4'h0, 4'h0, 0, 2'd0, 5'd0);
        tbl[25] = mk(0, 4'h0, 16'h0000, 16'h0000, 4'h0, 4'h0, 4'h0, 1, 2'd1, 5'd4);
        tbl[26] = mk(0, 4'h0, 16'h0000, 16'h0000, 4'h0, 4'h0, 4'h0, 0, 2'd0, 5'd0);

        drive(1, 4'h0, 16'h0, 16'h0);
        repeat (2) @(posedge clk);
        #1;

        for (int i = 0; i < NV; i++) begin
            drive(tbl[i].rst, tbl[i].valid, tbl[i].a, tbl[i].b);
            @(negedge clk);
            chk($sformatf("row%0d req_ready", i), 32'(req_ready), 32'(tbl[i].ready));
            chk($sformatf("row%0d add_a", i), 32'(add_a), 32'(tbl[i].xa));
            chk($sformatf("row%0d add_b", i), 32'(add_b), 32'(tbl[i].xb));
            chk($sformatf("row%0d rsp_valid", i), 32'(rsp_valid), 32'(tbl[i].rv));
            if (tbl[i].rv) begin
                chk($sformatf("row%0d rsp_id", i), 32'(rsp_id), 32'(tbl[i].rid));
                chk($sformatf("row%0d rsp_sum", i), 32'(rsp_sum), 32'(tbl[i].rsum));
            end
            @(posedge clk);
            #1;
        end

        // Pointer is 2: req3 wins over req0; req0 then changes operands before its grant.
        drive(0, 4'h9, 16'h9001, 16'h9001);
        @(negedge clk);
        chk("hs1 req_ready", 32'(req_ready), 32'h8);
        chk("hs1 add_a", 32'(add_a), 32'h9);
        @(posedge clk);
        #1;
        drive(0, 4'h1, 16'h0006, 16'h0006);
        @(negedge clk);
        chk("hs2 req_ready", 32'(req_ready), 32'h1);
        chk("hs2 add_a", 32'(add_a), 32'h6);
        @(posedge clk);
        #1;
        drive(0, 4'h0, 16'h0, 16'h0);
        got = 1'b0;
        for (int n = 0; n < 6 && !got; n++) begin
            @(negedge clk);
            if (rsp_valid) got = 1'b1;
            else @(posedge clk);
        end
        chk("hs rsp_timeout", 32'(got), 32'h1);
        chk("hs rsp0 id", 32'(rsp_id), 32'd3);
        chk("hs rsp0 sum", 32'(rsp_sum), 32'd18);
        @(posedge clk);
        #1;
        @(negedge clk);
        chk("hs rsp1 valid", 32'(rsp_valid), 32'h1);
        chk("hs rsp1 id", 32'(rsp_id), 32'd0);
        chk("hs rsp1 sum", 32'(rsp_sum), 32'd12);
        @(posedge clk);
        #1;
        @(negedge clk);
        chk("hs rsp2 valid", 32'(rsp_valid), 32'h0);

        $display("Result: errors=%0d of %0d checks", errs, checks);
        $finish;
    end

endmodule
